// File: rtl/dispatcher_pkg.sv
// Shared dispatcher types: workgroup sequencer states and the per-WG descriptor.
package dispatcher_pkg;

  localparam int WF_COUNT_WIDTH  = 4;
  localparam int WAVE_ITEM_WIDTH = 6;
  localparam int VGPR_ID_WIDTH   = 8;
  localparam int SGPR_ID_WIDTH   = 4;
  localparam int LDS_ID_WIDTH    = 8;
  localparam int GDS_ID_WIDTH    = 14;
  localparam int MEM_ADDR_WIDTH  = 32;

  typedef enum logic [2:0] {
    WG_SEQ_IDLE,
    WG_SEQ_ISSUE,
    WG_SEQ_GAP,
    WG_SEQ_STALL,
    WG_SEQ_DRAIN
  } wg_seq_state_t;

  typedef struct packed {
    logic [WF_COUNT_WIDTH-1:0]  num_wf;
    logic [WAVE_ITEM_WIDTH-1:0] wf_size;
    logic [VGPR_ID_WIDTH:0]     vgpr_size_total;
    logic [SGPR_ID_WIDTH:0]     sgpr_size_total;
    logic [LDS_ID_WIDTH:0]      lds_size_total;
    logic [GDS_ID_WIDTH:0]      gds_size_total;
    logic [VGPR_ID_WIDTH:0]     vgpr_size_per_wf;
    logic [SGPR_ID_WIDTH:0]     sgpr_size_per_wf;
    logic [MEM_ADDR_WIDTH-1:0]  start_pc;
  } wg_desc_t;

endpackage

// File: rtl/dispatcher_wg_sequencer_if.sv
// Host-side workgroup offer/ack and retire channel between the sequencer and the dispatcher.
interface dispatcher_wg_sequencer_if #(
  parameter int WG_ID_WIDTH = 6
);
  import dispatcher_pkg::*;

  logic                       host_wg_valid;
  logic [WG_ID_WIDTH-1:0]     host_wg_id;
  logic [WF_COUNT_WIDTH-1:0]  host_num_wf;
  logic [WAVE_ITEM_WIDTH-1:0] host_wf_size;
  logic [VGPR_ID_WIDTH:0]     host_vgpr_size_total;
  logic [SGPR_ID_WIDTH:0]     host_sgpr_size_total;
  logic [LDS_ID_WIDTH:0]      host_lds_size_total;
  logic [GDS_ID_WIDTH:0]      host_gds_size_total;
  logic [VGPR_ID_WIDTH:0]     host_vgpr_size_per_wf;
  logic [SGPR_ID_WIDTH:0]     host_sgpr_size_per_wf;
  logic [MEM_ADDR_WIDTH-1:0]  host_start_pc;
  logic                       inflight_wg_buffer_host_rcvd_ack;
  logic                       inflight_wg_buffer_host_wf_done;
  logic [WG_ID_WIDTH-1:0]     inflight_wg_buffer_host_wf_done_wg_id;

  modport master (
    output host_wg_valid, host_wg_id, host_num_wf, host_wf_size,
           host_vgpr_size_total, host_sgpr_size_total, host_lds_size_total,
           host_gds_size_total, host_vgpr_size_per_wf, host_sgpr_size_per_wf,
           host_start_pc,
    input  inflight_wg_buffer_host_rcvd_ack, inflight_wg_buffer_host_wf_done,
           inflight_wg_buffer_host_wf_done_wg_id
  );

  modport slave (
    input  host_wg_valid, host_wg_id, host_num_wf, host_wf_size,
           host_vgpr_size_total, host_sgpr_size_total, host_lds_size_total,
           host_gds_size_total, host_vgpr_size_per_wf, host_sgpr_size_per_wf,
           host_start_pc,
    output inflight_wg_buffer_host_rcvd_ack, inflight_wg_buffer_host_wf_done,
           inflight_wg_buffer_host_wf_done_wg_id
  );

endinterface

// File: rtl/dispatcher_wg_scoreboard.sv
// Outstanding-workgroup bitmap; flags retires of unissued ids, retires in IDLE and stray acks.
module dispatcher_wg_scoreboard #(
  parameter int WG_ID_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   ack_fire,
  input  logic [WG_ID_WIDTH-1:0] ack_id,
  input  logic                   retire,
  input  logic [WG_ID_WIDTH-1:0] retire_id,
  input  logic                   idle,
  input  logic                   stray_ack,
  output logic                   seq_error
);

  localparam int DEPTH = 1 << WG_ID_WIDTH;

  logic [DEPTH-1:0] outstanding;
  logic [DEPTH-1:0] outstanding_next;
  logic             bad_retire;

  always_comb begin
    outstanding_next = outstanding;
    bad_retire       = retire && (idle || !outstanding[retire_id]);
    if (retire && !idle) outstanding_next[retire_id] = 1'b0;
    if (ack_fire)        outstanding_next[ack_id]    = 1'b1;
    if (clear)           outstanding_next            = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      seq_error   <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      if (bad_retire || stray_ack) seq_error <= 1'b1;
    end
  end

endmodule

// File: rtl/dispatcher_wg_sequencer.sv
// Issues workgroups 0..N-1 of one kernel under valid/ack, caps outstanding WGs, pulses kernel_done.
// Defining DISPATCHER_WG_SEQ_SCOREBOARD_EN adds the outstanding-id scoreboard and the seq_error port.
//
// state | meaning
// IDLE  | waiting for cfg_start
// ISSUE | offering WG `issued` until ack
// GAP   | one dead cycle between offers
// STALL | MAX_INFLIGHT outstanding, waiting for a retire
// DRAIN | all issued, waiting for the last retire
module dispatcher_wg_sequencer
  import dispatcher_pkg::*;
#(
  parameter int WG_ID_WIDTH  = 6,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic [WG_ID_WIDTH:0]       cfg_num_wg,
  input  logic [WF_COUNT_WIDTH-1:0]  cfg_num_wf,
  input  logic [WAVE_ITEM_WIDTH-1:0] cfg_wf_size,
  input  logic [VGPR_ID_WIDTH:0]     cfg_vgpr_size_total,
  input  logic [SGPR_ID_WIDTH:0]     cfg_sgpr_size_total,
  input  logic [LDS_ID_WIDTH:0]      cfg_lds_size_total,
  input  logic [GDS_ID_WIDTH:0]      cfg_gds_size_total,
  input  logic [VGPR_ID_WIDTH:0]     cfg_vgpr_size_per_wf,
  input  logic [SGPR_ID_WIDTH:0]     cfg_sgpr_size_per_wf,
  input  logic [MEM_ADDR_WIDTH-1:0]  cfg_start_pc,
  dispatcher_wg_sequencer_if.master  host,
  output logic                       busy,
  output logic                       kernel_done
`ifdef DISPATCHER_WG_SEQ_SCOREBOARD_EN
  ,
  output logic                       seq_error
`endif
);

  localparam int            CW             = WG_ID_WIDTH + 1;
  localparam logic [CW-1:0] MAX_INFLIGHT_C = CW'(MAX_INFLIGHT);

  wg_seq_state_t          state, state_next;
  logic [CW-1:0]          issued, retired, inflight, num_wg;
  logic [CW-1:0]          issued_next, retired_next;
  wg_desc_t               desc;
  logic                   valid_q, valid_next;
  logic [WG_ID_WIDTH-1:0] wg_id_q;
  logic                   busy_next, done_next;
  logic                   start_ok, ack_fire, retire_cnt;

  assign inflight   = issued - retired;
  assign start_ok   = (state == WG_SEQ_IDLE) && cfg_start;
  assign ack_fire   = valid_q && host.inflight_wg_buffer_host_rcvd_ack;
  assign retire_cnt = (state != WG_SEQ_IDLE) && host.inflight_wg_buffer_host_wf_done;

  always_comb begin
    state_next   = state;
    valid_next   = 1'b0;
    busy_next    = 1'b1;
    done_next    = 1'b0;
    issued_next  = issued + CW'(ack_fire);
    retired_next = retired + CW'(retire_cnt);
    unique case (state)
      WG_SEQ_IDLE: begin
        busy_next = 1'b0;
        if (cfg_start) begin
          state_next   = WG_SEQ_ISSUE;
          valid_next   = 1'b1;
          busy_next    = 1'b1;
          issued_next  = '0;
          retired_next = '0;
        end
      end
      WG_SEQ_ISSUE: begin
        valid_next = 1'b1;
        if (ack_fire) begin
          valid_next = 1'b0;
          if (issued_next == num_wg)
            state_next = WG_SEQ_DRAIN;
          else if (inflight + CW'(1) == MAX_INFLIGHT_C)
            state_next = WG_SEQ_STALL;
          else
            state_next = WG_SEQ_GAP;
        end
      end
      WG_SEQ_GAP: begin
        state_next = WG_SEQ_ISSUE;
        valid_next = 1'b1;
      end
      WG_SEQ_STALL: begin
        if (retire_cnt) begin
          state_next = WG_SEQ_ISSUE;
          valid_next = 1'b1;
        end
      end
      WG_SEQ_DRAIN: begin
        if (retired_next == num_wg) begin
          state_next = WG_SEQ_IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = WG_SEQ_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WG_SEQ_IDLE;
      issued      <= '0;
      retired     <= '0;
      num_wg      <= '0;
      desc        <= '0;
      valid_q     <= 1'b0;
      wg_id_q     <= '0;
      busy        <= 1'b0;
      kernel_done <= 1'b0;
    end else begin
      state       <= state_next;
      issued      <= issued_next;
      retired     <= retired_next;
      valid_q     <= valid_next;
      wg_id_q     <= issued_next[WG_ID_WIDTH-1:0];
      busy        <= busy_next;
      kernel_done <= done_next;
      if (start_ok) begin
        // A zero-sized kernel still runs one workgroup.
        num_wg                <= (cfg_num_wg == '0) ? CW'(1) : cfg_num_wg;
        desc.num_wf           <= cfg_num_wf;
        desc.wf_size          <= cfg_wf_size;
        desc.vgpr_size_total  <= cfg_vgpr_size_total;
        desc.sgpr_size_total  <= cfg_sgpr_size_total;
        desc.lds_size_total   <= cfg_lds_size_total;
        desc.gds_size_total   <= cfg_gds_size_total;
        desc.vgpr_size_per_wf <= cfg_vgpr_size_per_wf;
        desc.sgpr_size_per_wf <= cfg_sgpr_size_per_wf;
        desc.start_pc         <= cfg_start_pc;
      end
    end
  end

  assign host.host_wg_valid         = valid_q;
  assign host.host_wg_id            = wg_id_q;
  assign host.host_num_wf           = desc.num_wf;
  assign host.host_wf_size          = desc.wf_size;
  assign host.host_vgpr_size_total  = desc.vgpr_size_total;
  assign host.host_sgpr_size_total  = desc.sgpr_size_total;
  assign host.host_lds_size_total   = desc.lds_size_total;
  assign host.host_gds_size_total   = desc.gds_size_total;
  assign host.host_vgpr_size_per_wf = desc.vgpr_size_per_wf;
  assign host.host_sgpr_size_per_wf = desc.sgpr_size_per_wf;
  assign host.host_start_pc         = desc.start_pc;

`ifdef DISPATCHER_WG_SEQ_SCOREBOARD_EN
  dispatcher_wg_scoreboard #(
    .WG_ID_WIDTH (WG_ID_WIDTH)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .ack_fire  (ack_fire),
    .ack_id    (wg_id_q),
    .retire    (host.inflight_wg_buffer_host_wf_done),
    .retire_id (host.inflight_wg_buffer_host_wf_done_wg_id),
    .idle      (state == WG_SEQ_IDLE),
    .stray_ack (host.inflight_wg_buffer_host_rcvd_ack && !valid_q),
    .seq_error (seq_error)
  );
`endif

endmodule

// File: tb/tb_dispatcher_wg_sequencer.sv
// Randomized and directed bench for dispatcher_wg_sequencer against a count-based issue model.
`timescale 1ns/1ps
module tb_dispatcher_wg_sequencer;
  import dispatcher_pkg::*;

  localparam int W    = 6;
  localparam int MAXI = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                       cfg_start;
  logic [W:0]                 cfg_num_wg;
  logic [WF_COUNT_WIDTH-1:0]  cfg_num_wf;
  logic [WAVE_ITEM_WIDTH-1:0] cfg_wf_size;
  logic [VGPR_ID_WIDTH:0]     cfg_vgpr_size_total;
  logic [SGPR_ID_WIDTH:0]     cfg_sgpr_size_total;
  logic [LDS_ID_WIDTH:0]      cfg_lds_size_total;
  logic [GDS_ID_WIDTH:0]      cfg_gds_size_total;
  logic [VGPR_ID_WIDTH:0]     cfg_vgpr_size_per_wf;
  logic [SGPR_ID_WIDTH:0]     cfg_sgpr_size_per_wf;
  logic [MEM_ADDR_WIDTH-1:0]  cfg_start_pc;
  logic                       busy1, kd1, busy2, kd2;
`ifdef DISPATCHER_WG_SEQ_SCOREBOARD_EN
  logic                       err1, err2;
`endif

  dispatcher_wg_sequencer_if #(.WG_ID_WIDTH(W)) if1 ();
  dispatcher_wg_sequencer_if #(.WG_ID_WIDTH(W)) if2 ();

  dispatcher_wg_sequencer #(.WG_ID_WIDTH(W), .MAX_INFLIGHT(MAXI)) u_dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_wg(cfg_num_wg),
    .cfg_num_wf(cfg_num_wf), .cfg_wf_size(cfg_wf_size),
    .cfg_vgpr_size_total(cfg_vgpr_size_total), .cfg_sgpr_size_total(cfg_sgpr_size_total),
    .cfg_lds_size_total(cfg_lds_size_total), .cfg_gds_size_total(cfg_gds_size_total),
    .cfg_vgpr_size_per_wf(cfg_vgpr_size_per_wf), .cfg_sgpr_size_per_wf(cfg_sgpr_size_per_wf),
    .cfg_start_pc(cfg_start_pc), .host(if1), .busy(busy1), .kernel_done(kd1)
`ifdef DISPATCHER_WG_SEQ_SCOREBOARD_EN
    , .seq_error(err1)
`endif
  );

  dispatcher_wg_sequencer #(.WG_ID_WIDTH(W), .MAX_INFLIGHT(2)) u_dut2 (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_wg(cfg_num_wg),
    .cfg_num_wf(cfg_num_wf), .cfg_wf_size(cfg_wf_size),
    .cfg_vgpr_size_total(cfg_vgpr_size_total), .cfg_sgpr_size_total(cfg_sgpr_size_total),
    .cfg_lds_size_total(cfg_lds_size_total), .cfg_gds_size_total(cfg_gds_size_total),
    .cfg_vgpr_size_per_wf(cfg_vgpr_size_per_wf), .cfg_sgpr_size_per_wf(cfg_sgpr_size_per_wf),
    .cfg_start_pc(cfg_start_pc), .host(if2), .busy(busy2), .kernel_done(kd2)
`ifdef DISPATCHER_WG_SEQ_SCOREBOARD_EN
    , .seq_error(err2)
`endif
  );

  int checks = 0;
  int errors = 0;

  function automatic wg_desc_t rand_desc();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[$bits(wg_desc_t)-1:0];
  endfunction

  function automatic wg_desc_t obs1();
    wg_desc_t o;
    o.num_wf           = if1.host_num_wf;
    o.wf_size          = if1.host_wf_size;
    o.vgpr_size_total  = if1.host_vgpr_size_total;
    o.sgpr_size_total  = if1.host_sgpr_size_total;
    o.lds_size_total   = if1.host_lds_size_total;
    o.gds_size_total   = if1.host_gds_size_total;
    o.vgpr_size_per_wf = if1.host_vgpr_size_per_wf;
    o.sgpr_size_per_wf = if1.host_sgpr_size_per_wf;
    o.start_pc         = if1.host_start_pc;
    return o;
  endfunction

  task automatic apply_cfg(input int num, input wg_desc_t d);
    cfg_num_wg           = (W+1)'(num);
    cfg_num_wf           = d.num_wf;
    cfg_wf_size          = d.wf_size;
    cfg_vgpr_size_total  = d.vgpr_size_total;
    cfg_sgpr_size_total  = d.sgpr_size_total;
    cfg_lds_size_total   = d.lds_size_total;
    cfg_gds_size_total   = d.gds_size_total;
    cfg_vgpr_size_per_wf = d.vgpr_size_per_wf;
    cfg_sgpr_size_per_wf = d.sgpr_size_per_wf;
    cfg_start_pc         = d.start_pc;
  endtask

  // Drive one cycle of dispatcher inputs, then land on the next falling edge.
  task automatic step1(input logic a, input logic d, input logic [W-1:0] id);
    if1.inflight_wg_buffer_host_rcvd_ack      = a;
    if1.inflight_wg_buffer_host_wf_done       = d;
    if1.inflight_wg_buffer_host_wf_done_wg_id = id;
    @(negedge clk);
  endtask

  task automatic step2(input logic a, input logic d, input logic [W-1:0] id);
    if2.inflight_wg_buffer_host_rcvd_ack      = a;
    if2.inflight_wg_buffer_host_wf_done       = d;
    if2.inflight_wg_buffer_host_wf_done_wg_id = id;
    @(negedge clk);
  endtask

  task automatic start_kernel(input int num, input wg_desc_t d);
    apply_cfg(num, d);
    cfg_start = 1'b1;
    step1(1'b0, 1'b0, '0);
    cfg_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step2(1'b0, 1'b0, '0);
    step1(1'b0, 1'b0, '0);
    rst = 1'b0;
  endtask

  // Model keeps only counts: WGs issued, WGs retired, a one-cycle cooldown after
  // each accepted offer, and a stalled flag raised when the cap is reached.
  task automatic run_kernel(input string tag, input int num_cfg, input int ack_pct,
                            input int dmin, input int dmax, input int stray_pct);
    int num, issued, retired, now;
    bit cool, stalled, active, exp_valid, exp_kd, done_seen, a, fire, r, cap_hit;
    logic [W-1:0] rid;
    int due_q[$];
    int id_q[$];
    wg_desc_t d;
    num = (num_cfg == 0) ? 1 : num_cfg;
    d = rand_desc();
    start_kernel(num_cfg, d);
    issued = 0; retired = 0; cool = 0; stalled = 0; active = 1;
    exp_valid = 1; exp_kd = 0; done_seen = 0;
    checks++;
    if (obs1() !== d) begin
      errors++; $display("FAIL %s desc_latch: got %h want %h", tag, obs1(), d);
    end
    for (now = 0; now < 5000; now++) begin
      checks++;
      if (if1.host_wg_valid !== exp_valid) begin
        errors++; $display("FAIL %s valid cyc %0d: got %b want %b", tag, now, if1.host_wg_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (if1.host_wg_id !== issued[W-1:0]) begin
          errors++; $display("FAIL %s wg_id cyc %0d: got %0d want %0d", tag, now, if1.host_wg_id, issued);
        end
      end
      checks++;
      if (busy1 !== active) begin
        errors++; $display("FAIL %s busy cyc %0d: got %b want %b", tag, now, busy1, active);
      end
      checks++;
      if (kd1 !== exp_kd) begin
        errors++; $display("FAIL %s kernel_done cyc %0d: got %b want %b", tag, now, kd1, exp_kd);
      end
      if (exp_kd) begin
        done_seen = 1;
        break;
      end
      a = exp_valid ? ($urandom_range(99) < ack_pct) : ($urandom_range(99) < stray_pct);
      fire = a && exp_valid;
      r = 0; rid = '0;
      for (int i = 0; i < due_q.size(); i++) begin
        if (due_q[i] <= now) begin
          r = 1; rid = W'(id_q[i]);
          due_q.delete(i); id_q.delete(i);
          break;
        end
      end
      if (fire) begin
        due_q.push_back(now + int'($urandom_range(dmax, dmin)));
        id_q.push_back(issued);
      end
      if1.inflight_wg_buffer_host_rcvd_ack      = a;
      if1.inflight_wg_buffer_host_wf_done       = r;
      if1.inflight_wg_buffer_host_wf_done_wg_id = rid;
      exp_kd = (issued == num) && (retired + int'(r) == num);
      if (fire) begin
        cap_hit = ((issued - retired) + 1 == MAXI) && (issued + 1 != num);
        stalled = cap_hit;
        cool    = !cap_hit && (issued + 1 != num);
      end else begin
        if (stalled && r) stalled = 0;
        cool = 0;
      end
      issued  += int'(fire);
      retired += int'(r);
      active    = !exp_kd;
      exp_valid = active && (issued < num) && !cool && !stalled;
      @(negedge clk);
    end
    step1(1'b0, 1'b0, '0);
    checks++;
    if (!done_seen) begin
      errors++; $display("FAIL %s timeout: kernel_done got 0 want 1 within budget", tag);
    end
    checks++;
    if (obs1() !== d) begin
      errors++; $display("FAIL %s desc_stable: got %h want %h", tag, obs1(), d);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (if1.host_wg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if1.host_wg_valid); end
    checks++; if (if1.host_wg_id !== '0) begin errors++; $display("FAIL reset_id: got %0d want 0", if1.host_wg_id); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy1); end
    checks++; if (kd1 !== 1'b0) begin errors++; $display("FAIL reset_kd: got %b want 0", kd1); end
    checks++; if (obs1() !== '0) begin errors++; $display("FAIL reset_desc: got %h want 0", obs1()); end
    checks++; if (if2.host_wg_valid !== 1'b0 || busy2 !== 1'b0 || kd2 !== 1'b0) begin
      errors++; $display("FAIL reset_dut2: got valid %b busy %b kd %b want 0 0 0", if2.host_wg_valid, busy2, kd2);
    end
`ifdef DISPATCHER_WG_SEQ_SCOREBOARD_EN
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_seq_error: got %b want 0", err1); end
`endif
  endtask

  task automatic test_basic();
    do_reset();
    run_kernel("basic", 4, 100, 3, 3, 0);
  endtask

  task automatic test_stall();
    int acks;
    do_reset();
    apply_cfg(5, rand_desc());
    cfg_start = 1'b1;
    step2(1'b0, 1'b0, '0);
    cfg_start = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (if2.host_wg_valid) acks++;
      step2(if2.host_wg_valid, 1'b0, '0);
    end
    checks++; if (acks != 2) begin errors++; $display("FAIL stall_acks: got %0d want 2", acks); end
    checks++; if (if2.host_wg_valid !== 1'b0 || busy2 !== 1'b1) begin
      errors++; $display("FAIL stall_hold: got valid %b busy %b want 0 1", if2.host_wg_valid, busy2);
    end
    step2(1'b0, 1'b1, 6'd0);
    checks++; if (if2.host_wg_valid !== 1'b1) begin errors++; $display("FAIL stall_release_valid: got %b want 1", if2.host_wg_valid); end
    checks++; if (if2.host_wg_id !== 6'd2) begin errors++; $display("FAIL stall_release_id: got %0d want 2", if2.host_wg_id); end
    step2(1'b0, 1'b0, '0);
  endtask

  task automatic test_same_cycle();
    do_reset();
    start_kernel(4, rand_desc());
    step1(1'b1, 1'b0, '0);
    step1(1'b0, 1'b0, '0);
    step1(1'b1, 1'b1, 6'd0);
    checks++; if (u_dut.issued !== 7'd2) begin errors++; $display("FAIL same_issued: got %0d want 2", u_dut.issued); end
    checks++; if (u_dut.retired !== 7'd1) begin errors++; $display("FAIL same_retired: got %0d want 1", u_dut.retired); end
    checks++; if (u_dut.inflight !== 7'd1) begin errors++; $display("FAIL same_inflight: got %0d want 1", u_dut.inflight); end
    step1(1'b0, 1'b0, '0);
    checks++; if (if1.host_wg_valid !== 1'b1 || if1.host_wg_id !== 6'd2) begin
      errors++; $display("FAIL same_next_offer: got valid %b id %0d want 1 2", if1.host_wg_valid, if1.host_wg_id);
    end
    step1(1'b1, 1'b1, 6'd1);
    step1(1'b0, 1'b0, '0);
    step1(1'b1, 1'b0, '0);
    step1(1'b0, 1'b1, 6'd2);
    checks++; if (kd1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("FAIL same_early_done: got kd %b busy %b want 0 1", kd1, busy1); end
    step1(1'b0, 1'b1, 6'd3);
    checks++; if (kd1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL same_done: got kd %b busy %b want 1 0", kd1, busy1); end
    step1(1'b0, 1'b0, '0);
    checks++; if (kd1 !== 1'b0) begin errors++; $display("FAIL same_done_pulse: got %b want 0", kd1); end
  endtask

  task automatic test_start_in_drain();
    wg_desc_t d1;
    do_reset();
    d1 = rand_desc();
    start_kernel(2, d1);
    step1(1'b1, 1'b0, '0);
    step1(1'b0, 1'b0, '0);
    step1(1'b1, 1'b0, '0);
    apply_cfg(7, ~d1);
    cfg_start = 1'b1;
    step1(1'b0, 1'b0, '0);
    cfg_start = 1'b0;
    checks++; if (obs1() !== d1) begin errors++; $display("FAIL drain_desc: got %h want %h", obs1(), d1); end
    checks++; if (busy1 !== 1'b1 || if1.host_wg_valid !== 1'b0) begin
      errors++; $display("FAIL drain_state: got busy %b valid %b want 1 0", busy1, if1.host_wg_valid);
    end
    step1(1'b0, 1'b1, 6'd0);
    checks++; if (kd1 !== 1'b0) begin errors++; $display("FAIL drain_early_done: got %b want 0", kd1); end
    step1(1'b0, 1'b1, 6'd1);
    checks++; if (kd1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL drain_done: got kd %b busy %b want 1 0", kd1, busy1); end
    checks++; if (obs1() !== d1) begin errors++; $display("FAIL drain_desc_after: got %h want %h", obs1(), d1); end
    step1(1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_kernel(8, rand_desc());
    for (int i = 0; i < 3; i++) begin
      step1(1'b1, 1'b0, '0);
      step1(1'b0, 1'b0, '0);
    end
    checks++; if (if1.host_wg_valid !== 1'b1 || if1.host_wg_id !== 6'd3) begin
      errors++; $display("FAIL rstmid_pre: got valid %b id %0d want 1 3", if1.host_wg_valid, if1.host_wg_id);
    end
    rst = 1'b1;
    step1(1'b0, 1'b0, '0);
    rst = 1'b0;
    checks++; if (if1.host_wg_valid !== 1'b0 || busy1 !== 1'b0 || kd1 !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: got valid %b busy %b kd %b want 0 0 0", if1.host_wg_valid, busy1, kd1);
    end
    checks++; if (obs1() !== '0) begin errors++; $display("FAIL rstmid_desc: got %h want 0", obs1()); end
    start_kernel(2, rand_desc());
    checks++; if (if1.host_wg_valid !== 1'b1 || if1.host_wg_id !== 6'd0) begin
      errors++; $display("FAIL rstmid_fresh: got valid %b id %0d want 1 0", if1.host_wg_valid, if1.host_wg_id);
    end
    do_reset();
  endtask

  task automatic test_random();
    int nums[6];
    nums = '{0, 1, 64, 0, 0, 0};
    for (int k = 3; k < 6; k++) nums[k] = int'($urandom_range(63, 2));
    do_reset();
    foreach (nums[k])
      run_kernel($sformatf("rand%0d", k), nums[k], int'($urandom_range(100, 40)),
                 1, int'($urandom_range(60, 2)), 20);
  endtask

`ifdef DISPATCHER_WG_SEQ_SCOREBOARD_EN
  task automatic test_scoreboard();
    do_reset();
    start_kernel(2, rand_desc());
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL sb_clean: got %b want 0", err1); end
    step1(1'b0, 1'b1, 6'd5);
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL sb_bad_retire: got %b want 1", err1); end
    repeat (4) step1(1'b0, 1'b0, '0);
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL sb_sticky: got %b want 1", err1); end
    do_reset();
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL sb_rst_clear: got %b want 0", err1); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0;
    apply_cfg(0, '0);
    if1.inflight_wg_buffer_host_rcvd_ack = 1'b0;
    if1.inflight_wg_buffer_host_wf_done = 1'b0;
    if1.inflight_wg_buffer_host_wf_done_wg_id = '0;
    if2.inflight_wg_buffer_host_rcvd_ack = 1'b0;
    if2.inflight_wg_buffer_host_wf_done = 1'b0;
    if2.inflight_wg_buffer_host_wf_done_wg_id = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_same_cycle();
    test_start_in_drain();
    test_reset_mid();
    test_random();
`ifdef DISPATCHER_WG_SEQ_SCOREBOARD_EN
    test_scoreboard();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
